// File: rtl/krv_apb_pkg.sv
// Shared definitions for the AHB-lite to APB bridge: FSM encoding, AHB
// response/transfer codes and the APB slave count.
package krv_apb_pkg;

   localparam int NUM_APB_SLV = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_ERR1   = 3'd3,
      ST_ERR2   = 3'd4
   } apb_state_e;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // NONSEQ and SEQ are the only transfer types that start a bridge cycle.
   function automatic logic is_active_trans(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

   function automatic logic [NUM_APB_SLV-1:0] slv_onehot(input logic [1:0] idx);
      logic [NUM_APB_SLV-1:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: 4-bit slave index to one-hot PSEL; indices
// beyond the implemented slaves flag a decode miss.
module apb_addr_decode
   import krv_apb_pkg::*;
(
   input  logic [3:0]             slv_idx,
   output logic [NUM_APB_SLV-1:0] psel_onehot,
   output logic                   decode_miss
);

   // Index decode with miss detection for unpopulated slots
   always_comb begin
      psel_onehot = {NUM_APB_SLV{1'b0}};
      decode_miss = 1'b1;
      if (slv_idx[3:2] == 2'b00) begin
         psel_onehot = slv_onehot(slv_idx[1:0]);
         decode_miss = 1'b0;
      end else begin
         psel_onehot = {NUM_APB_SLV{1'b0}};
         decode_miss = 1'b1;
      end
   end

endmodule

// File: rtl/apb_ctrl.sv
// AHB-lite slave to APB master bridge with four decoded APB slaves,
// access timeout and a two-cycle AHB ERROR response.
module apb_ctrl
   import krv_apb_pkg::*;
#(
   parameter int TIMEOUT      = 255,
   parameter int SLV_BASE_BIT = 12
)(
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   output logic [3:0]  PSEL,
   output logic        PENABLE,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

   apb_state_e       state_r;
   apb_state_e       state_nxt_s;
   apb_state_e       accept_state_s;
   logic [7:0]       cnt_r;
   logic [7:0]       cnt_nxt_s;
   logic [7:0]       cnt_inc_s;
   logic [3:0]       psel_r;
   logic [3:0]       psel_nxt_s;
   logic [3:0]       accept_psel_s;
   logic             penable_r;
   logic             penable_nxt_s;
   logic [31:0]      paddr_r;
   logic             pwrite_r;
   logic [3:0]       slv_idx_s;
   logic [3:0]       dec_psel_s;
   logic             dec_miss_s;
   logic             addr_valid_s;
   logic             accept_s;
   logic             hreadyout_s;
   logic [1:0]       hresp_s;
   logic [31:0]      hrdata_s;

   assign slv_idx_s    = HADDR[SLV_BASE_BIT+3:SLV_BASE_BIT];
   assign addr_valid_s = HSEL & HREADY & is_active_trans(HTRANS);
   assign cnt_inc_s    = cnt_r + 8'd1;

   apb_addr_decode u_decode (
      .slv_idx     (slv_idx_s),
      .psel_onehot (dec_psel_s),
      .decode_miss (dec_miss_s)
   );

   // Where an accepted address phase goes: APB setup, or straight to error
   always_comb begin
      accept_state_s = ST_SETUP;
      accept_psel_s  = 4'b0000;
      if (dec_miss_s) begin
         accept_state_s = ST_ERR1;
         accept_psel_s  = 4'b0000;
      end else begin
         accept_state_s = ST_SETUP;
         accept_psel_s  = dec_psel_s;
      end
   end

   // Next-state, next APB controls and AHB response
   always_comb begin
      state_nxt_s   = state_r;
      psel_nxt_s    = psel_r;
      penable_nxt_s = penable_r;
      cnt_nxt_s     = cnt_r;
      accept_s      = 1'b0;
      hreadyout_s   = 1'b1;
      hresp_s       = HRESP_OKAY;
      case (state_r)
         ST_IDLE: begin
            penable_nxt_s = 1'b0;
            if (addr_valid_s) begin
               accept_s    = 1'b1;
               state_nxt_s = accept_state_s;
               psel_nxt_s  = accept_psel_s;
            end else begin
               state_nxt_s = ST_IDLE;
               psel_nxt_s  = 4'b0000;
            end
         end
         ST_SETUP: begin
            hreadyout_s   = 1'b0;
            state_nxt_s   = ST_ACCESS;
            penable_nxt_s = 1'b1;
            cnt_nxt_s     = 8'd0;
         end
         ST_ACCESS: begin
            hreadyout_s = PREADY & ~PSLVERR;
            if (PREADY) begin
               penable_nxt_s = 1'b0;
               if (PSLVERR) begin
                  state_nxt_s = ST_ERR1;
                  psel_nxt_s  = 4'b0000;
               end else if (addr_valid_s) begin
                  accept_s    = 1'b1;
                  state_nxt_s = accept_state_s;
                  psel_nxt_s  = accept_psel_s;
               end else begin
                  state_nxt_s = ST_IDLE;
                  psel_nxt_s  = 4'b0000;
               end
            end else if (cnt_inc_s == TIMEOUT_C) begin
               // Slave never answered: abandon the access and report ERROR
               cnt_nxt_s     = cnt_inc_s;
               state_nxt_s   = ST_ERR1;
               psel_nxt_s    = 4'b0000;
               penable_nxt_s = 1'b0;
            end else begin
               cnt_nxt_s = cnt_inc_s;
            end
         end
         ST_ERR1: begin
            hreadyout_s   = 1'b0;
            hresp_s       = HRESP_ERROR;
            state_nxt_s   = ST_ERR2;
            psel_nxt_s    = 4'b0000;
            penable_nxt_s = 1'b0;
         end
         ST_ERR2: begin
            hresp_s       = HRESP_ERROR;
            penable_nxt_s = 1'b0;
            if (addr_valid_s) begin
               accept_s    = 1'b1;
               state_nxt_s = accept_state_s;
               psel_nxt_s  = accept_psel_s;
            end else begin
               state_nxt_s = ST_IDLE;
               psel_nxt_s  = 4'b0000;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            psel_nxt_s    = 4'b0000;
            penable_nxt_s = 1'b0;
         end
      endcase
   end

   // Read data is only forwarded while an APB access is in progress
   always_comb begin
      hrdata_s = 32'h0000_0000;
      if (state_r == ST_ACCESS) begin
         hrdata_s = PRDATA;
      end else begin
         hrdata_s = 32'h0000_0000;
      end
   end

   // Bridge state, APB control registers and address capture
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 8'd0;
         psel_r    <= 4'b0000;
         penable_r <= 1'b0;
         paddr_r   <= 32'h0000_0000;
         pwrite_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         psel_r    <= psel_nxt_s;
         penable_r <= penable_nxt_s;
         if (accept_s) begin
            paddr_r  <= HADDR;
            pwrite_r <= HWRITE;
         end
      end
   end

   // HWDATA is held stable by the wait states inserted during SETUP/ACCESS
   assign PWDATA    = HWDATA;
   assign PSEL      = psel_r;
   assign PENABLE   = penable_r;
   assign PADDR     = paddr_r;
   assign PWRITE    = pwrite_r;
   assign HREADYOUT = hreadyout_s;
   assign HRESP     = hresp_s;
   assign HRDATA    = hrdata_s;

endmodule

// File: tb/tb_apb_ctrl.sv
// Directed vector bench for apb_ctrl (TIMEOUT=4): per-cycle table plus an
// asynchronous reset sequence.
module tb_apb_ctrl;

   localparam logic [1:0] T_IDL = 2'b00;
   localparam logic [1:0] T_BSY = 2'b01;
   localparam logic [1:0] T_NS  = 2'b10;
   localparam logic [1:0] R_OK  = 2'b00;
   localparam logic [1:0] R_ER  = 2'b01;
   localparam int         NVEC  = 33;

   logic        HCLK;
   logic        HRESETN;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic [3:0]  PSEL;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic        hready;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic        pready;
      logic        pslverr;
      logic [31:0] prdata;
      logic        e_hro;
      logic [1:0]  e_hresp;
      logic [3:0]  e_psel;
      logic        e_pen;
      logic [31:0] e_hrdata;
      logic [31:0] e_paddr;
      logic        e_pwrite;
   } vec_t;

   vec_t vecs [NVEC];

   apb_ctrl #(.TIMEOUT(4), .SLV_BASE_BIT(12)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
      .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input logic hsel, input logic [1:0] htrans, input logic hwrite, input logic hready,
      input logic [31:0] haddr, input logic [31:0] hwdata,
      input logic pready, input logic pslverr, input logic [31:0] prdata,
      input logic e_hro, input logic [1:0] e_hresp, input logic [3:0] e_psel, input logic e_pen,
      input logic [31:0] e_hrdata, input logic [31:0] e_paddr, input logic e_pwrite);
      vec_t v;
      v.hsel = hsel;       v.htrans = htrans;   v.hwrite = hwrite;   v.hready = hready;
      v.haddr = haddr;     v.hwdata = hwdata;   v.pready = pready;   v.pslverr = pslverr;
      v.prdata = prdata;   v.e_hro = e_hro;     v.e_hresp = e_hresp; v.e_psel = e_psel;
      v.e_pen = e_pen;     v.e_hrdata = e_hrdata; v.e_paddr = e_paddr; v.e_pwrite = e_pwrite;
      return v;
   endfunction

   task automatic drive(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                        input logic [31:0] haddr, input logic pready);
      HSEL = hsel; HTRANS = htrans; HWRITE = hwrite; HADDR = haddr;
      HREADY = 1'b1; HWDATA = 32'h0; PREADY = pready; PSLVERR = 1'b0; PRDATA = 32'h0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      HSEL = v.hsel; HTRANS = v.htrans; HWRITE = v.hwrite; HREADY = v.hready;
      HADDR = v.haddr; HWDATA = v.hwdata; PREADY = v.pready; PSLVERR = v.pslverr;
      PRDATA = v.prdata;
      #4;
      n_vec++;
      if (HREADYOUT !== v.e_hro || HRESP !== v.e_hresp || PSEL !== v.e_psel ||
          PENABLE !== v.e_pen || HRDATA !== v.e_hrdata || PADDR !== v.e_paddr ||
          PWRITE !== v.e_pwrite || PWDATA !== v.hwdata) begin
         n_err++;
         $display("FAIL vec%0d: got hro=%b hresp=%b psel=%b pen=%b hrdata=%h paddr=%h pwrite=%b pwdata=%h; expected hro=%b hresp=%b psel=%b pen=%b hrdata=%h paddr=%h pwrite=%b pwdata=%h",
                  idx, HREADYOUT, HRESP, PSEL, PENABLE, HRDATA, PADDR, PWRITE, PWDATA,
                  v.e_hro, v.e_hresp, v.e_psel, v.e_pen, v.e_hrdata, v.e_paddr, v.e_pwrite, v.hwdata);
      end
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      // idle transfer types, then write to slave 1 with zero APB wait
      vecs[0]  = mk(1'b1, T_IDL, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
      vecs[1]  = mk(1'b1, T_BSY, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
      vecs[2]  = mk(1'b1, T_NS,  1'b1, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
      vecs[3]  = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0010, 1'b0, 32'h0, 32'h0000_1004, 1'b1);
      vecs[4]  = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, R_OK, 4'b0010, 1'b1, 32'hDEAD_BEEF, 32'h0000_1004, 1'b1);
      // read slave 3 with three wait cycles
      vecs[5]  = mk(1'b1, T_NS,  1'b0, 1'b1, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0000_1004, 1'b1);
      vecs[6]  = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, R_OK, 4'b1000, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
      for (int i = 7; i <= 9; i++)
         vecs[i] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b1000, 1'b1, 32'h0, 32'h0000_3000, 1'b0);
      vecs[10] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b1, R_OK, 4'b1000, 1'b1, 32'h1234_5678, 32'h0000_3000, 1'b0);
      // read slave 2 answered with PSLVERR
      vecs[11] = mk(1'b1, T_NS,  1'b0, 1'b1, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
      vecs[12] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0100, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
      vecs[13] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, R_OK, 4'b0100, 1'b1, 32'h0, 32'h0000_2000, 1'b0);
      vecs[14] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
      vecs[15] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
      // decode miss, then a transfer accepted in ERR2
      vecs[16] = mk(1'b1, T_NS,  1'b1, 1'b1, 32'h0000_8000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
      vecs[17] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0000_8000, 1'b1);
      vecs[18] = mk(1'b1, T_NS,  1'b1, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0000_8000, 1'b1);
      // slave 0 never ready: four ACCESS cycles then ERROR
      vecs[19] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0001, 1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 20; i <= 23; i++)
         vecs[i] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0001, 1'b1, 32'h0, 32'h0, 1'b1);
      vecs[24] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
      vecs[25] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_ER, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
      // back-to-back writes: slave 0 then slave 1 with no IDLE between
      vecs[26] = mk(1'b1, T_NS,  1'b1, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
      vecs[27] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0000_00AA, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0001, 1'b0, 32'h0, 32'h0, 1'b1);
      vecs[28] = mk(1'b1, T_NS,  1'b1, 1'b1, 32'h0000_1008, 32'h0000_00AA, 1'b1, 1'b0, 32'h0, 1'b1, R_OK, 4'b0001, 1'b1, 32'h0, 32'h0, 1'b1);
      vecs[29] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0000_00BB, 1'b0, 1'b0, 32'h0, 1'b0, R_OK, 4'b0010, 1'b0, 32'h0, 32'h0000_1008, 1'b1);
      vecs[30] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0000_00BB, 1'b1, 1'b0, 32'h0, 1'b1, R_OK, 4'b0010, 1'b1, 32'h0, 32'h0000_1008, 1'b1);
      // HREADY low blocks acceptance
      vecs[31] = mk(1'b1, T_NS,  1'b0, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0000_1008, 1'b1);
      vecs[32] = mk(1'b0, T_IDL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, R_OK, 4'b0000, 1'b0, 32'h0, 32'h0000_1008, 1'b1);

      HRESETN = 1'b0;
      drive(1'b0, T_IDL, 1'b0, 32'h0, 1'b0);
      #1;
      chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("rst_hresp", {30'h0, HRESP}, 32'h0);
      chk("rst_psel_pen", {27'h0, PSEL, PENABLE}, 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETN = 1'b1;

      for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

      // reset asserted mid-ACCESS on a write to slave 2
      drive(1'b1, T_NS, 1'b1, 32'h0000_2000, 1'b0);
      @(posedge HCLK); #1;
      drive(1'b0, T_IDL, 1'b0, 32'h0, 1'b0);
      @(posedge HCLK); #1;
      chk("pre_rst_access", {27'h0, PSEL, PENABLE}, {27'h0, 4'b0100, 1'b1});
      #2;
      HRESETN = 1'b0;
      #1;
      chk("mid_rst_psel_pen", {27'h0, PSEL, PENABLE}, 32'h0);
      chk("mid_rst_paddr", PADDR, 32'h0);
      chk("mid_rst_pwrite", {31'h0, PWRITE}, 32'h0);
      chk("mid_rst_hready_resp", {29'h0, HREADYOUT, HRESP}, {29'h0, 1'b1, 2'b00});
      drive(1'b1, T_NS, 1'b0, 32'h0000_1000, 1'b0);
      @(posedge HCLK); #1;
      HRESETN = 1'b1;
      @(posedge HCLK); #1;
      chk("post_rst_setup_psel", {27'h0, PSEL, PENABLE}, {27'h0, 4'b0010, 1'b0});
      chk("post_rst_paddr", PADDR, 32'h0000_1000);
      chk("post_rst_hreadyout", {31'h0, HREADYOUT}, 32'h0);
      drive(1'b0, T_IDL, 1'b0, 32'h0, 1'b1);
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      chk("post_rst_done", {27'h0, PSEL, PENABLE}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_ctrl.md
APB_CTRL -- requirements
Module: apb_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, number of ACCESS cycles without PREADY before the transfer is aborted (range 1..255).
REQ-002 Parameter: SLV_BASE_BIT, 12, LSB of the 4-bit slave-select field in HADDR.
REQ-003 HCLK  in  1  clock; all state updates on the rising edge.
REQ-004 HRESETN  in  1  reset, asynchronous, active-low.
REQ-005 HSEL  in  1  AHB-lite slave select.
REQ-006 HADDR  in  32  AHB address.
REQ-007 HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ.
REQ-008 HWRITE  in  1  AHB write flag.
REQ-009 HWDATA  in  32  AHB write data, valid in the data phase.
REQ-010 HREADY  in  1  AHB bus ready (qualifies the address phase).
REQ-011 HREADYOUT  out  1  slave ready to AHB.
REQ-012 HRESP  out  2  00 OKAY, 01 ERROR.
REQ-013 HRDATA  out  32  read data to AHB.
REQ-014 PSEL  out  4  one-hot APB slave select.
REQ-015 PENABLE  out  1  APB access phase.
REQ-016 PADDR  out  32  APB address.
REQ-017 PWRITE  out  1  APB direction.
REQ-018 PWDATA  out  32  APB write data.
REQ-019 PRDATA  in  32  OR-combined slave read data.
REQ-020 PREADY  in  1  OR-combined slave ready.
REQ-021 PSLVERR  in  1  OR-combined slave error.

Function
REQ-022 A transfer is accepted when HSEL and HREADY and HTRANS[1] are all 1 at a rising edge while in IDLE, or while in ACCESS on its completing cycle, or in ERR2.
REQ-023 On acceptance, HADDR and HWRITE are registered into PADDR/PWRITE; slave index = HADDR[SLV_BASE_BIT+3:SLV_BASE_BIT].
REQ-024 FSM states: IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-025 Accepted transfer with index 0..3 goes to SETUP; index 4..15 (decode miss) goes to ERR1 with no APB activity.
REQ-026 SETUP: PSEL[index]=1, PENABLE=0, HREADYOUT=0; one cycle, then ACCESS.
REQ-027 ACCESS: PSEL held, PENABLE=1; HREADYOUT=PREADY and !PSLVERR.
REQ-028 ACCESS with PREADY=1 and PSLVERR=0: HRESP=OKAY, complete; next state SETUP if a new transfer is accepted in that cycle, else IDLE.
REQ-029 ACCESS with PREADY=1 and PSLVERR=1: next state ERR1.
REQ-030 ERR1: HREADYOUT=0, HRESP=ERROR, PSEL=0, PENABLE=0; one cycle, then ERR2.
REQ-031 ERR2: HREADYOUT=1, HRESP=ERROR; next state per REQ-025 if a transfer is accepted, else IDLE.
REQ-032 Timeout: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0; when it equals TIMEOUT, PSEL/PENABLE drop the next cycle and the state goes to ERR1.
REQ-033 PWDATA = HWDATA combinationally; this is valid because HREADYOUT=0 through SETUP/ACCESS holds HWDATA stable.
REQ-034 HRDATA = PRDATA in ACCESS, else 0.
REQ-035 IDLE: HREADYOUT=1, HRESP=OKAY, PSEL=0, PENABLE=0.
REQ-036 HSEL=1 with HTRANS IDLE/BUSY is not a transfer: OKAY, zero wait states, no APB activity.

Reset
REQ-037 HRESETN low asynchronously forces: state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, timeout counter 0, HREADYOUT=1, HRESP=OKAY.
REQ-038 Reset mid-transfer aborts the transfer with no completion; the first post-reset edge behaves as IDLE.

Structure
REQ-039 Shared package krv_apb_pkg holds: FSM state encoding, HRESP codes (OKAY/ERROR), HTRANS codes, and NUM_APB_SLV=4.
REQ-040 Sub-module apb_addr_decode (combinational): index to one-hot PSEL plus a decode-miss flag.

Verification
REQ-041 Write 0x0000_1004 data 0xA5A5_5A5A, PREADY=1 -> PSEL=0010 for 2 cycles; PENABLE=1 in the 2nd cycle; PWDATA=0xA5A5_5A5A; HREADYOUT low 1 cycle, OKAY.
REQ-042 Read 0x0000_3000, PREADY low 3 ACCESS cycles then PRDATA=0x1234_5678 -> PSEL=1000; HRDATA=0x1234_5678 with HREADYOUT=1 on the completing cycle.
REQ-043 Read 0x0000_2000 with PSLVERR=1 on PREADY -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then IDLE.
REQ-044 Access 0x0000_8000 -> no PSEL asserted; two-cycle ERROR response.
REQ-045 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; ERROR response; PSEL=0.
REQ-046 Back-to-back writes to slaves 0 then 1, second accepted on the completing cycle -> SETUP for slave 1 follows immediately with no IDLE cycle; async reset asserted mid-ACCESS -> all outputs return to reset values immediately.
